// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch stage: PC register, 2-entry {pc, instr} buffer, decode handshake
module instr_fetch_unit #(
  parameter int unsigned      PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                fetch_enable,
  output logic [PC_WIDTH-1:0] PC_new,
  input  logic [31:0]         Instr,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                id_valid,
  input  logic                id_ready,
  output logic [31:0]         id_instr,
  output logic [PC_WIDTH-1:0] id_pc
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t              state;
  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] head_pc;
  logic [31:0]         head_instr;
  logic [PC_WIDTH-1:0] tail_pc;
  logic [31:0]         tail_instr;
  logic                pop;
  logic                fire;

  assign PC_new   = pc_q;
  assign id_valid = (state != EMPTY);
  assign id_pc    = head_pc;
  assign id_instr = head_instr;

  assign pop  = id_valid & id_ready;
  assign fire = fetch_enable & ~redirect_valid & ((state != FULL) | pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else if (redirect_valid) begin
      pc_q <= redirect_pc;
    end else if (fire) begin
      pc_q <= pc_q + PC_WIDTH'(1);
    end
  end

  // Head is always the oldest entry; tail is only meaningful in FULL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      head_pc    <= '0;
      head_instr <= '0;
      tail_pc    <= '0;
      tail_instr <= '0;
    end else if (redirect_valid) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (fire) begin
            head_pc    <= pc_q;
            head_instr <= Instr;
            state      <= ONE;
          end
        end
        ONE: begin
          if (pop && fire) begin
            head_pc    <= pc_q;
            head_instr <= Instr;
          end else if (pop) begin
            state <= EMPTY;
          end else if (fire) begin
            tail_pc    <= pc_q;
            tail_instr <= Instr;
            state      <= FULL;
          end
        end
        FULL: begin
          // A push while FULL is only possible together with a pop.
          if (pop) begin
            head_pc    <= tail_pc;
            head_instr <= tail_instr;
            if (fire) begin
              tail_pc    <= pc_q;
              tail_instr <= Instr;
            end else begin
              state <= ONE;
            end
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage directly upstream of the instruction memory. Owns the program counter and drives PC_new into the word-addressed, combinational instruction memory. Captures the returned Instr together with its PC into a 2-entry output buffer. Presents {pc, instr} to decode over a valid/ready handshake, with branch/jump redirect and flush.

Parameters:
PC_WIDTH, 32, width of PC_new / redirect_pc / id_pc (word index, not byte address).
RESET_PC, 0, PC value loaded on reset.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous, active-low reset
fetch_enable  input  1  1 = fetching permitted; 0 = PC frozen, no new pushes
PC_new  output  PC_WIDTH  word index to instruction memory; driven directly from PC register
Instr  input  32  instruction word from memory, valid combinationally in the same cycle as PC_new
redirect_valid  input  1  one-cycle pulse: flush buffer, load redirect_pc
redirect_pc  input  PC_WIDTH  new fetch target
id_valid  output  1  head buffer entry valid
id_ready  input  1  decode accepts head entry this cycle
id_instr  output  32  instruction of head entry
id_pc  output  PC_WIDTH  PC of head entry

Behaviour:
- Clock and reset: one clock (clk); rst_n asynchronous, active-low. Reset is asserted asynchronously and released synchronously to clk.
- Reset values: PC = RESET_PC, so PC_new = RESET_PC. Buffer count = 0, id_valid = 0, id_instr = 0, id_pc = 0. Reset mid-operation discards all buffered entries immediately.
- Internal signals:
  - pop = id_valid & id_ready.
  - fire = fetch_enable & ~redirect_valid & (count < 2 | pop).
- On fire:
  - {PC, Instr} is pushed at the buffer tail.
  - PC <= PC + 1, modulo 2^PC_WIDTH. All-ones wraps to 0 with no flag.
- On ~fire and ~redirect_valid: PC holds, and PC_new stays stable.
- Buffer:
  - 2-entry FIFO; head drives id_* directly from registers. No combinational path from Instr to id_*.
  - count update: +1 on push only, -1 on pop only, unchanged on push & pop in the same cycle.
  - Push and pop in the same cycle with count = 2 is legal: head advances and the new entry fills the tail.
  - Push into count = 0: entry appears at id_* the next cycle.
- Latency: PC presented in cycle t → id_valid = 1 with id_pc = that PC in cycle t+1, given an empty buffer and no redirect.
- Throughput: 1 instruction/cycle while id_ready = 1.
- Hold rule: while id_valid & ~id_ready, id_instr and id_pc hold stable, and id_valid stays 1 until popped or flushed.
- Redirect (highest priority, overrides fire):
  - Next cycle: count = 0, id_valid = 0, PC = redirect_pc.
  - No push in the redirect cycle.
  - A pop in the redirect cycle is honoured (decode consumed the head). All other entries are discarded.
  - Redirect with fetch_enable = 0 still loads PC and flushes.
- States, derived from count: EMPTY (0), ONE (1), FULL (2).
  - FULL with ~id_ready → PC frozen (stall).
  - FULL with id_ready → steady stream.
- fetch_enable falling: entries already buffered still drain normally.
- No duplication or loss: every PC issued while fire = 1 and not flushed appears on id_* exactly once, in order.

Test Plan:
- Stream: reset with RESET_PC = 0, fetch_enable = 1, id_ready = 1, memory preloaded with mem[k] = k + 0x100 → PC_new = 0,1,2,… per cycle; cycle 1 shows id_pc = 0, id_instr = 0x100; cycle 2 shows id_pc = 1, id_instr = 0x101; id_valid constantly 1.
- Backpressure: stream, then id_ready = 0 for 4 cycles → count reaches 2, PC_new frozen at head PC + 2, and id_pc/id_instr held. Reassert id_ready → the sequence continues with no gap, duplicate, or loss.
- Redirect while FULL: count = 2, id_ready = 0, redirect_valid with redirect_pc = 40 → next cycle id_valid = 0 and PC_new = 40; cycle after that id_pc = 40, id_instr = mem[40].
- Redirect with pop: count = 2, id_ready = 1, redirect_pc = 7 → head consumed once; second entry never appears; next valid output is id_pc = 7.
- Wrap: RESET_PC = 0xFFFFFFFF → PC_new goes 0xFFFFFFFF then 0x00000000; id_pc follows the same order.
- Async reset: assert rst_n = 0 mid-cycle with count = 2 → id_valid = 0 and PC_new = RESET_PC immediately, without waiting for a clock edge. After release, streaming resumes from RESET_PC.
